snake_dir_ctrl: RTL and testbench



---
 rtl/snake_dir_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// Button debounce plus IDLE/RUN/PAUSE direction controller for the snake game.
// Define SNAKE_DIR_QUEUE_EN for a 2-entry turn FIFO; otherwise one latest-wins pending turn.
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       step,
  input  logic       lose,
  output logic [2:0] move,
  output logic       paused
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 center.
  logic [4:0] btn_raw;
  logic [4:0] press;

  assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      logic             s1_reg;
      logic             s2_reg;
      logic             db_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          db_reg    <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= btn_raw[gi];
          s2_reg    <= s1_reg;
          press_reg <= 1'b0;
          if (s2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_reg    <= s2_reg;
            press_reg <= s2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic       dir_press;
  logic [1:0] dir_sel;

  always_comb begin
    dir_press = 1'b1;
    dir_sel   = DIR_RIGHT;
    if (press[0])      dir_sel = DIR_UP;
    else if (press[1]) dir_sel = DIR_DOWN;
    else if (press[2]) dir_sel = DIR_LEFT;
    else if (press[3]) dir_sel = DIR_RIGHT;
    else               dir_press = 1'b0;
  end

  logic [1:0] state_reg, state_next;
  logic [1:0] committed_reg, committed_next;
  logic [2:0] move_reg, move_next;
  logic       paused_reg, paused_next;
  logic [1:0] ref_dir;
  logic       accept;

`ifdef SNAKE_DIR_QUEUE_EN
  logic [1:0] pend0_reg, pend0_next;
  logic [1:0] pend1_reg, pend1_next;
  logic [1:0] pend_cnt_reg, pend_cnt_next;
`else
  logic       pend_valid_reg, pend_valid_next;
  logic [1:0] pend_dir_reg, pend_dir_next;
`endif

  always_comb begin
    state_next     = state_reg;
    committed_next = committed_reg;
    ref_dir        = committed_reg;
    accept         = 1'b0;
`ifdef SNAKE_DIR_QUEUE_EN
    pend0_next     = pend0_reg;
    pend1_next     = pend1_reg;
    pend_cnt_next  = pend_cnt_reg;
`else
    pend_valid_next = pend_valid_reg;
    pend_dir_next   = pend_dir_reg;
`endif

    if (lose) begin
      state_next = IDLE;
`ifdef SNAKE_DIR_QUEUE_EN
      pend_cnt_next = 2'd0;
`else
      pend_valid_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (dir_press) begin
            committed_next = dir_sel;
            state_next     = RUN;
          end
        end
        RUN: begin
          // Commit on step first, so a same-cycle press is judged against the new reference.
`ifdef SNAKE_DIR_QUEUE_EN
          if (step && pend_cnt_reg != 2'd0) begin
            committed_next = pend0_reg;
            pend0_next     = pend1_reg;
            pend_cnt_next  = pend_cnt_reg - 2'd1;
          end
          if (pend_cnt_next == 2'd2)      ref_dir = pend1_next;
          else if (pend_cnt_next == 2'd1) ref_dir = pend0_next;
          else                            ref_dir = committed_next;
          accept = dir_press && (dir_sel != ref_dir) && (dir_sel != (ref_dir ^ 2'b10))
                   && (pend_cnt_next != 2'd2);
          if (accept) begin
            if (pend_cnt_next == 2'd0) pend0_next = dir_sel;
            else                       pend1_next = dir_sel;
            pend_cnt_next = pend_cnt_next + 2'd1;
          end
`else
          if (step && pend_valid_reg) begin
            committed_next  = pend_dir_reg;
            pend_valid_next = 1'b0;
          end
          ref_dir = committed_next;
          accept  = dir_press && (dir_sel != ref_dir) && (dir_sel != (ref_dir ^ 2'b10));
          if (accept) begin
            pend_valid_next = 1'b1;
            pend_dir_next   = dir_sel;
          end
`endif
          if (press[4]) state_next = PAUSE;
        end
        PAUSE: begin
          if (press[4]) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end

    move_next   = (state_next == RUN) ? {1'b0, committed_next} : 3'b100;
    paused_next = (state_next == PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      committed_reg <= DIR_RIGHT;
      move_reg      <= 3'b100;
      paused_reg    <= 1'b0;
`ifdef SNAKE_DIR_QUEUE_EN
      pend0_reg     <= 2'b00;
      pend1_reg     <= 2'b00;
      pend_cnt_reg  <= 2'd0;
`else
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= 2'b00;
`endif
    end else begin
      state_reg     <= state_next;
      committed_reg <= committed_next;
      move_reg      <= move_next;
      paused_reg    <= paused_next;
`ifdef SNAKE_DIR_QUEUE_EN
      pend0_reg     <= pend0_next;
      pend1_reg     <= pend1_next;
      pend_cnt_reg  <= pend_cnt_next;
`else
      pend_valid_reg <= pend_valid_next;
      pend_dir_reg   <= pend_dir_next;
`endif
    end
  end

  assign move   = move_reg;
  assign paused = paused_reg;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4; expectations follow SNAKE_DIR_QUEUE_EN.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic       step = 1'b0;
  logic       lose = 1'b0;
  logic [2:0] move;
  logic       paused;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  typedef struct packed {
    logic [2:0]  mv;
    logic        ps;
    logic [31:0] cyc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] last_obs = 4'b1000;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_CENTER = 4;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .step(step), .lose(lose), .move(move), .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:     btn_up = v;
      B_DOWN:   btn_down = v;
      B_LEFT:   btn_left = v;
      B_RIGHT:  btn_right = v;
      default:  btn_center = v;
    endcase
  endtask

  // Returns with the press pulse live; it is consumed at the next rising edge.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(6);
    set_btn(b, 1'b0);
  endtask

  task automatic press2(input int a, input int b);
    set_btn(a, 1'b1);
    set_btn(b, 1'b1);
    tick(6);
    set_btn(a, 1'b0);
    set_btn(b, 1'b0);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic expect_move(input logic [2:0] mv, input logic ps, input int lat);
    exp_t e;
    e.mv  = mv;
    e.ps  = ps;
    e.cyc = 32'(ecount + lat);
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [2:0] mv, input logic ps);
    checks++;
    if (move !== mv || paused !== ps) begin
      errors++;
      $display("FAIL %s: got move=%b paused=%b, want move=%b paused=%b", name, move, paused, mv, ps);
    end else begin
      $display("ok   %s: move=%b paused=%b", name, move, paused);
    end
  endtask

  task automatic monitor_step();
    logic [3:0] obs;
    exp_t       e;
    obs = {move, paused};
    if (!rst && obs !== last_obs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got move=%b paused=%b at cycle %0d, want no change",
                 move, paused, ecount);
      end else begin
        e = sb.pop_front();
        if (obs !== {e.mv, e.ps} || 32'(ecount) != e.cyc) begin
          errors++;
          $display("FAIL output_change: got move=%b paused=%b at cycle %0d, want move=%b paused=%b at cycle %0d",
                   move, paused, ecount, e.mv, e.ps, e.cyc);
        end else begin
          $display("ok   output_change: move=%b paused=%b at cycle %0d", move, paused, ecount);
        end
      end
    end
    last_obs = obs;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    tick(3);
    check_now("in_reset", 3'b100, 1'b0);
    rst = 1'b0;
    tick(2);
    check_now("after_reset", 3'b100, 1'b0);

    // IDLE: first direction press starts the game without a step.
    expect_move(3'b000, 1'b0, 7);
    press(B_RIGHT);
    tick(8);
    check_now("idle_start_right", 3'b000, 1'b0);

    // Reversal is dropped; a perpendicular turn commits one cycle after step.
    press(B_LEFT);
    tick(8);
    do_step();
    tick(3);
    check_now("reverse_rejected", 3'b000, 1'b0);
    press(B_UP);
    tick(8);
    expect_move(3'b001, 1'b0, 1);
    do_step();
    tick(3);

    // Glitchy button never stays stable for the debounce window.
    set_btn(B_LEFT, 1'b1); tick(3);
    set_btn(B_LEFT, 1'b0); tick(1);
    set_btn(B_LEFT, 1'b1); tick(3);
    set_btn(B_LEFT, 1'b0); tick(10);
    do_step();
    tick(3);
    check_now("glitch_ignored", 3'b001, 1'b0);

`ifdef SNAKE_DIR_QUEUE_EN
    press(B_RIGHT); tick(8);
    press(B_DOWN);  tick(8);
    expect_move(3'b000, 1'b0, 1);
    do_step(); tick(3);
    expect_move(3'b011, 1'b0, 1);
    do_step(); tick(3);
    check_now("queue_two_turns", 3'b011, 1'b0);
`else
    press(B_RIGHT); tick(8);
    press(B_DOWN);  tick(8);
    expect_move(3'b000, 1'b0, 1);
    do_step(); tick(3);
    do_step(); tick(3);
    check_now("single_pending_reverse", 3'b000, 1'b0);
    press(B_UP);   tick(8);
    press(B_DOWN); tick(8);
    expect_move(3'b011, 1'b0, 1);
    do_step(); tick(3);
    check_now("latest_wins", 3'b011, 1'b0);
`endif

    // Pause and resume.
    expect_move(3'b100, 1'b1, 7);
    press(B_CENTER);
    tick(8);
    do_step(); tick(2);
    do_step(); tick(2);
    check_now("paused_hold", 3'b100, 1'b1);
    expect_move(3'b011, 1'b0, 7);
    press(B_CENTER);
    tick(8);
    check_now("resumed", 3'b011, 1'b0);

    // Lose beats a same-cycle press and flushes the pending turn.
    press(B_LEFT);
    tick(8);
    press(B_DOWN);
    expect_move(3'b100, 1'b0, 1);
    lose = 1'b1;
    tick(2);
    press(B_UP);
    tick(2);
    lose = 1'b0;
    tick(6);
    check_now("lose_idle", 3'b100, 1'b0);
    expect_move(3'b001, 1'b0, 7);
    press(B_UP);
    tick(8);
    do_step();
    tick(3);
    check_now("restart_no_reversal_check", 3'b001, 1'b0);

    // Simultaneous up+left: up wins and is dropped as a repeat, left is discarded.
    press2(B_UP, B_LEFT);
    tick(8);
    do_step();
    tick(3);
    check_now("press_priority", 3'b001, 1'b0);

    tick(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
